// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// Holds the FSM state encoding, command codes and frame-width helper.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA,
        ST_WAIT_TX,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int rx_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and RAM-side signals of the SPI slave, bundled.
// slave modport is the DUT view, master the driving side.
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    import spi_slave_pkg::*;

    localparam int RX_W = rx_width(DATA_W);

    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              MISO;
    logic              rx_valid;
    logic [RX_W-1:0]   rx_data;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output MISO, rx_valid, rx_data, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_valid, rx_data, frame_err, busy
    );

endinterface

// File: rtl/spi_slave_param_tx.sv
// MISO serialiser: loads a word, puts its first bit out on the same edge,
// then shifts one bit per enabled cycle; output drops to 0 when idle.
module spi_tx_shifter #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_shift_en,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_sr;
    logic [CW-1:0]     r_cnt;
    logic              r_active;
    logic              r_miso;
    logic              w_done;

    assign w_done = r_active && (r_cnt == CW'(DATA_W));
    assign o_done = w_done;
    assign o_miso = r_miso;

    // Load, shift out remaining bits, or park MISO at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_miso   <= 1'b0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_cnt    <= CW'(1);
            if (MSB_FIRST != 0) begin
                r_miso <= i_data[DATA_W-1];
                r_sr   <= {i_data[DATA_W-2:0], 1'b0};
            end else begin
                r_miso <= i_data[0];
                r_sr   <= {1'b0, i_data[DATA_W-1:1]};
            end
        end else if (i_shift_en && r_active && !w_done) begin
            r_cnt <= r_cnt + CW'(1);
            if (MSB_FIRST != 0) begin
                r_miso <= r_sr[DATA_W-1];
                r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
            end else begin
                r_miso <= r_sr[0];
                r_sr   <= {1'b0, r_sr[DATA_W-1:1]};
            end
        end else begin
            r_miso   <= 1'b0;
            r_active <= 1'b0;
            r_cnt    <= '0;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises command+payload frames and
// serialises RAM read data back on MISO, with timeout and abort reporting.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 1,
    parameter int TX_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int RX_W = rx_width(DATA_W);
    localparam int CW   = $clog2(RX_W);

    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [7:0]      r_to_cnt;
    logic            r_rx_type;
    logic            r_rx_valid;
    logic            r_frame_err;
    logic [RX_W-1:0] r_rx_data;

    logic w_last_bit;
    logic w_load;
    logic w_shift_en;
    logic w_tx_done;
    logic w_miso;

    assign w_last_bit = (r_bit_cnt == CW'(RX_W - 2));
    assign w_load     = (r_state == ST_WAIT_TX) && !bus.SS_n
                        && bus.tx_valid;
    assign w_shift_en = (r_state == ST_SEND) && !bus.SS_n;

    assign bus.MISO      = w_miso;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_data   = r_rx_data;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != ST_IDLE);

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_data     (bus.tx_data),
        .o_miso     (w_miso),
        .o_done     (w_tx_done)
    );

    // Frame FSM: abort on deselect first, then per-state sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_rx_type   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (bus.SS_n && (r_state != ST_IDLE)) begin
                r_state     <= ST_IDLE;
                r_frame_err <= (r_state != ST_DONE);
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!bus.SS_n) r_state <= ST_CHK_CMD;
                    end
                    ST_CHK_CMD: begin
                        r_rx_data[RX_W-1] <= bus.MOSI;
                        r_bit_cnt         <= '0;
                        if (!bus.MOSI)     r_state <= ST_WRITE;
                        else if (r_rx_type) r_state <= ST_READ_DATA;
                        else               r_state <= ST_READ_ADD;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        r_rx_data[RX_W-2:0] <= {r_rx_data[RX_W-3:0],
                                                bus.MOSI};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (w_last_bit) begin
                            r_rx_valid <= 1'b1;
                            if (r_state == ST_READ_DATA) begin
                                r_state  <= ST_WAIT_TX;
                                r_to_cnt <= '0;
                            end else begin
                                r_state <= ST_DONE;
                                if (r_state == ST_READ_ADD)
                                    r_rx_type <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_TX: begin
                        if (bus.tx_valid) begin
                            r_state <= ST_SEND;
                        end else if (r_to_cnt == 8'(TX_TIMEOUT - 1)) begin
                            r_frame_err <= 1'b1;
                            r_rx_type   <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end
                    ST_SEND: begin
                        if (w_tx_done) begin
                            r_rx_type <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: frame table plus hand sequences
// for read-back, timeout, aborts and mid-send reset.
module tb_spi_slave_param;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) bm ();
    spi_slave_if #(.DATA_W(8)) bl ();

    spi_slave_param #(
        .DATA_W(8), .MSB_FIRST(1), .TX_TIMEOUT(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    spi_slave_param #(
        .DATA_W(8), .MSB_FIRST(0), .TX_TIMEOUT(16)
    ) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bl)
    );

    typedef struct {
        logic [9:0] frame;
        state_t     st;
        logic       typ;
        logic       err;
        logic       txv;
    } vec_t;

    vec_t vt[6];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ss(input logic v);
        bm.SS_n = v;
        bl.SS_n = v;
    endtask

    task automatic set_mosi(input logic v);
        bm.MOSI = v;
        bl.MOSI = v;
    endtask

    task automatic set_tx(input logic v, input logic [7:0] d);
        bm.tx_valid = v;
        bl.tx_valid = v;
        bm.tx_data  = d;
        bl.tx_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_ss(1'b1);
        set_mosi(1'b0);
        set_tx(1'b0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            set_mosi(f[9-i]);
            tick();
            chk("rx_valid_timing", 32'(bm.rx_valid), 32'(i == 9));
            chk("miso_quiet_rx", 32'(bm.MISO), 32'd0);
        end
    endtask

    task automatic frame(input logic [9:0] f);
        set_ss(1'b0);
        tick();
        chk("busy_sel", 32'(bm.busy), 32'd1);
        send_bits(f, 10);
        chk("rx_data", 32'(bm.rx_data), 32'(f));
        chk("frame_err_rx", 32'(bm.frame_err), 32'd0);
    endtask

    task automatic release_ss(input logic exp_err);
        set_ss(1'b1);
        set_mosi(1'b0);
        tick();
        chk("frame_err_rel", 32'(bm.frame_err), 32'(exp_err));
        chk("busy_rel", 32'(bm.busy), 32'd0);
        chk("rx_valid_rel", 32'(bm.rx_valid), 32'd0);
        tick();
        chk("frame_err_pulse", 32'(bm.frame_err), 32'd0);
    endtask

    task automatic read_seq(input logic [7:0] d);
        frame(10'h23C);
        chk("rd_add_state", 32'(u_dut.r_state), 32'(ST_DONE));
        chk("rd_add_type", 32'(u_dut.r_rx_type), 32'd1);
        release_ss(1'b0);
        frame(10'h300);
        chk("rd_data_state", 32'(u_dut.r_state), 32'(ST_WAIT_TX));
        tick();
        chk("miso_wait1", 32'(bm.MISO), 32'd0);
        tick();
        chk("miso_wait2", 32'(bm.MISO), 32'd0);
        set_tx(1'b1, d);
        tick();
        set_tx(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("miso_msb", 32'(bm.MISO), 32'(d[7-i]));
            chk("miso_lsb", 32'(bl.MISO), 32'(d[i]));
            tick();
        end
        chk("miso_end_msb", 32'(bm.MISO), 32'd0);
        chk("miso_end_lsb", 32'(bl.MISO), 32'd0);
        chk("send_done", 32'(u_dut.r_state), 32'(ST_DONE));
        chk("send_type", 32'(u_dut.r_rx_type), 32'd0);
        release_ss(1'b0);
    endtask

    initial begin
        vt[0] = '{10'h0A5, ST_DONE,    1'b0, 1'b0, 1'b0};
        vt[1] = '{10'h15A, ST_DONE,    1'b0, 1'b0, 1'b1};
        vt[2] = '{10'h23C, ST_DONE,    1'b1, 1'b0, 1'b0};
        vt[3] = '{10'h0FF, ST_DONE,    1'b1, 1'b0, 1'b1};
        vt[4] = '{10'h211, ST_WAIT_TX, 1'b1, 1'b1, 1'b0};
        vt[5] = '{10'h3C3, ST_WAIT_TX, 1'b1, 1'b1, 1'b0};

        do_reset();
        chk("rst_miso", 32'(bm.MISO), 32'd0);
        chk("rst_rx_valid", 32'(bm.rx_valid), 32'd0);
        chk("rst_frame_err", 32'(bm.frame_err), 32'd0);
        chk("rst_rx_data", 32'(bm.rx_data), 32'd0);
        chk("rst_busy", 32'(bm.busy), 32'd0);
        chk("rst_type", 32'(u_dut.r_rx_type), 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_tx(vt[i].txv, 8'hFF);
            frame(vt[i].frame);
            chk("tbl_state", 32'(u_dut.r_state), 32'(vt[i].st));
            chk("tbl_type", 32'(u_dut.r_rx_type), 32'(vt[i].typ));
            set_tx(1'b0, 8'h00);
            release_ss(vt[i].err);
            chk("tbl_type_rel", 32'(u_dut.r_rx_type), 32'(vt[i].typ));
        end

        do_reset();
        read_seq(8'hC3);
        read_seq(8'h01);

        frame(10'h23C);
        release_ss(1'b0);
        frame(10'h300);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("to_frame_err", 32'(bm.frame_err), 32'(k == 16));
            chk("to_miso", 32'(bm.MISO), 32'd0);
        end
        chk("to_state", 32'(u_dut.r_state), 32'(ST_DONE));
        chk("to_type", 32'(u_dut.r_rx_type), 32'd0);
        tick();
        chk("to_err_pulse", 32'(bm.frame_err), 32'd0);
        release_ss(1'b0);

        set_ss(1'b0);
        tick();
        send_bits(10'h15A, 5);
        set_ss(1'b1);
        tick();
        chk("ab5_busy", 32'(bm.busy), 32'd0);
        chk("ab5_err", 32'(bm.frame_err), 32'd1);
        chk("ab5_rx_valid", 32'(bm.rx_valid), 32'd0);
        tick();
        chk("ab5_err_pulse", 32'(bm.frame_err), 32'd0);
        frame(10'h15A);
        chk("ab5_refr_state", 32'(u_dut.r_state), 32'(ST_DONE));
        release_ss(1'b0);

        set_ss(1'b0);
        tick();
        send_bits(10'h0A5, 9);
        set_mosi(1'b1);
        set_ss(1'b1);
        tick();
        chk("ablast_rx_valid", 32'(bm.rx_valid), 32'd0);
        chk("ablast_err", 32'(bm.frame_err), 32'd1);
        chk("ablast_busy", 32'(bm.busy), 32'd0);
        tick();

        frame(10'h0A5);
        for (int i = 0; i < 4; i++) begin
            set_mosi(i[0]);
            tick();
            chk("done_rx_valid", 32'(bm.rx_valid), 32'd0);
            chk("done_state", 32'(u_dut.r_state), 32'(ST_DONE));
            chk("done_rx_data", 32'(bm.rx_data), 32'h0A5);
            chk("done_miso", 32'(bm.MISO), 32'd0);
        end
        release_ss(1'b0);

        do_reset();
        frame(10'h3FF);
        chk("first_state", 32'(u_dut.r_state), 32'(ST_DONE));
        chk("first_type", 32'(u_dut.r_rx_type), 32'd1);
        release_ss(1'b0);
        frame(10'h300);
        chk("rst_send_wait", 32'(u_dut.r_state), 32'(ST_WAIT_TX));
        set_tx(1'b1, 8'hA5);
        tick();
        set_tx(1'b0, 8'h00);
        chk("rsend_b7", 32'(bm.MISO), 32'd1);
        tick();
        chk("rsend_b6", 32'(bm.MISO), 32'd0);
        tick();
        chk("rsend_b5", 32'(bm.MISO), 32'd1);
        rst = 1'b1;
        tick();
        chk("rsend_miso", 32'(bm.MISO), 32'd0);
        chk("rsend_type", 32'(u_dut.r_rx_type), 32'd0);
        chk("rsend_busy", 32'(bm.busy), 32'd0);
        chk("rsend_err", 32'(bm.frame_err), 32'd0);
        rst = 1'b0;
        set_ss(1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised successor of the team's 10-bit SPI slave front-end. It sits between the SPI pins and the single-port RAM wrapper.
- Deserialises command+payload frames of DATA_W+2 bits onto rx_data / rx_valid.
- On a read-data frame, waits for RAM read data (tx_valid / tx_data), then serialises it on MISO in a configurable bit order.
- New relative to the previous generation: configurable data width, a bounded tx_valid timeout, explicit frame-abort/error reporting, and a terminal DONE state that ignores trailing bits.

Parameters:
- DATA_W, 8, payload width; frame length RX_W = DATA_W+2 (2 command bits + payload).
- MSB_FIRST, 1, MISO shift order: 1 = tx_data[DATA_W-1] first, 0 = tx_data[0] first.
- TX_TIMEOUT, 16, maximum cycles spent in WAIT_TX before aborting; range 1..255.

Ports:
- clk, input, 1, single system clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- SS_n, input, 1, slave select, active-low; frames a transaction.
- MOSI, input, 1, serial in, sampled every clk while selected.
- tx_valid, input, 1, tx_data valid (RAM read return).
- tx_data, input, DATA_W, read data to shift out.
- MISO, output, 1, serial out (registered).
- rx_valid, output, 1, one-cycle pulse: rx_data holds a complete frame.
- rx_data, output, RX_W, received frame; [RX_W-1:RX_W-2] = command.
- frame_err, output, 1, one-cycle pulse on abort or timeout.
- busy, output, 1, high when state != IDLE (decode of state register).

Behaviour:
- Reset: state = IDLE; MISO, rx_valid, frame_err = 0; rx_data = 0; rx_type = 0; counters = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- IDLE:
  - SS_n = 0 -> CHK_CMD next cycle.
  - rx_valid and frame_err are 0 in every cycle without an event.
- CHK_CMD samples frame bit 0 into rx_data[RX_W-1]. Next state:
  - MOSI = 0 -> WRITE.
  - MOSI = 1 and rx_type = 0 -> READ_ADD.
  - MOSI = 1 and rx_type = 1 -> READ_DATA.
  - The branch is decided by rx_type, not by frame bit 1.
- WRITE / READ_ADD / READ_DATA sample bits 1..RX_W-1 into rx_data[RX_W-2..0], MSB-first, over RX_W-1 consecutive cycles.
  - rx_valid is high exactly 1 cycle, in the cycle after the last bit is sampled.
  - rx_data is stable from that cycle until the next frame begins shifting.
  - Latency: SS_n low seen at edge N -> rx_valid high in cycle N+RX_W+1.
- After reception:
  - WRITE -> DONE.
  - READ_ADD -> DONE, with rx_type set to 1.
  - READ_DATA -> WAIT_TX, with the timeout counter cleared.
- WAIT_TX:
  - tx_valid = 1 -> latch tx_data, go to SEND.
  - After TX_TIMEOUT cycles without tx_valid -> frame_err pulse, rx_type = 0, DONE.
- SEND:
  - MISO carries latched bits over DATA_W consecutive cycles; the first bit appears the cycle after the latch.
  - Bit order is set by MSB_FIRST.
  - After the last bit: MISO = 0, rx_type = 0, DONE.
- DONE: MOSI ignored, MISO = 0, no rx_valid.
- SS_n = 1 in any state other than IDLE -> IDLE next cycle. If the state was not DONE:
  - frame_err pulses 1 cycle;
  - no rx_valid;
  - rx_type is unchanged;
  - MISO is forced to 0.
- SS_n = 1 in the same cycle as the last payload bit: abort wins; no rx_valid, frame_err = 1.
- tx_valid outside WAIT_TX is ignored.
- rst in any state returns to the reset values on the next edge, overriding everything.

Decomposition:
- Package spi_slave_pkg holds:
  - the state enum;
  - command encodings CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11;
  - a function returning RX_W from DATA_W.
- One sub-module, spi_tx_shifter, parametrised by DATA_W and MSB_FIRST:
  - load/tx_data in;
  - serial MISO out;
  - done flag after DATA_W shifts.

Test Plan:
1. DATA_W = 8, SS_n low, MOSI frame 0,0,1,0,1,0,0,1,0,1 -> rx_valid single pulse 11 cycles after the SS_n-low edge, rx_data = 10'h0A5, state DONE, frame_err = 0.
2. Read-address frame 1,0,0x3C, then a read-data frame 1,1,0x00 with tx_valid = 1 three cycles after its rx_valid and tx_data = 8'hC3 -> MISO = 1,1,0,0,0,0,1,1 on consecutive cycles; rx_type = 0 afterwards.
3. MSB_FIRST = 0 repeating scenario 2 with tx_data = 8'h01 -> MISO = 1,0,0,0,0,0,0,0.
4. Read-data frame with tx_valid never asserted, TX_TIMEOUT = 16 -> frame_err pulse exactly 16 cycles after entering WAIT_TX, MISO stays 0, rx_type = 0.
5. SS_n raised after 5 bits of a write frame -> IDLE next cycle, frame_err pulse, no rx_valid; a following full frame decodes correctly.
6. First-ever frame 1,1,0xFF after reset -> treated as READ_ADD: rx_valid, rx_type = 1, no MISO activity; rst asserted mid-SEND -> MISO = 0, rx_type = 0 next cycle.
